// File: rtl/uart_autobaud_if.sv
// Control and result signals between the autobaud detector and its user.
// The master drives enable, arm request and the raw line; the slave reports the measurement.
interface uart_autobaud_if;
  localparam int unsigned BAUD_W = 12;

  logic              cfg_en;
  logic              start;
  logic              rxd;
  logic              busy;
  logic              done;
  logic              baud_valid;
  logic [BAUD_W-1:0] baud_16x;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output cfg_en, start, rxd,
    input  busy, done, baud_valid, baud_16x, err, err_code
  );

  modport slave (
    input  cfg_en, start, rxd,
    output busy, done, baud_valid, baud_16x, err, err_code
  );
endinterface

// File: rtl/uart_autobaud.sv
// Measures one 0x55 sync character on rxd and derives the 16x baud divider
// F_clk/(baud*16) - 2 from the span between its first and fifth falling edge.
module uart_autobaud #(
  parameter int unsigned CNT_W    = 20,
  parameter logic [11:0] RST_BAUD = 12'd0
) (
  input logic            app_clk,
  input logic            reset_n,
  uart_autobaud_if.slave bus
);

  localparam int unsigned EXT_W = CNT_W + 1;
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE, WAIT_HIGH, WAIT_EDGE1, MEASURE, CALC, ERROR
  } state_t;

  state_t            state, state_nxt;
  logic              rx_meta, rx_sync, rx_prev;
  logic              fall, mismatch, range_bad, at_max;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CNT_W-1:0]  prev_snap, prev_snap_nxt;
  logic [CNT_W-1:0]  t1, t1_nxt;
  logic [CNT_W-1:0]  c_total, c_total_nxt;
  logic [CNT_W-1:0]  snap, ti;
  logic [IDX_W-1:0]  edge_idx, edge_idx_nxt;
  logic [1:0]        err_pend, err_pend_nxt;
  logic [1:0]        err_code_q, err_code_nxt;
  logic [EXT_W-1:0]  diff, div;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic              err_q, err_nxt;
  logic              valid_q, valid_nxt;
  logic [11:0]       baud_q, baud_nxt;

  // Edge measurement and divider arithmetic
  assign fall      = rx_prev & ~rx_sync;
  assign at_max    = (cnt == CNT_MAX);
  assign snap      = cnt + CNT_W'(1);
  assign ti        = snap - prev_snap;
  assign diff      = (ti >= t1) ? (EXT_W'(ti) - EXT_W'(t1)) : (EXT_W'(t1) - EXT_W'(ti));
  assign mismatch  = diff > EXT_W'(t1 >> 2);
  assign div       = (EXT_W'(c_total) + EXT_W'(64)) >> 7;
  assign range_bad = (div < EXT_W'(3)) || (div > EXT_W'(4097));

  // State and datapath registers, synchroniser included
  always_ff @(posedge app_clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      cnt        <= '0;
      prev_snap  <= '0;
      t1         <= '0;
      c_total    <= '0;
      edge_idx   <= '0;
      err_pend   <= 2'b00;
      err_code_q <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      baud_q     <= RST_BAUD;
    end else begin
      state      <= state_nxt;
      rx_meta    <= bus.rxd;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      cnt        <= cnt_nxt;
      prev_snap  <= prev_snap_nxt;
      t1         <= t1_nxt;
      c_total    <= c_total_nxt;
      edge_idx   <= edge_idx_nxt;
      err_pend   <= err_pend_nxt;
      err_code_q <= err_code_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
      err_q      <= err_nxt;
      valid_q    <= valid_nxt;
      baud_q     <= baud_nxt;
    end
  end

  // Next-state; losing cfg_en returns to IDLE from anywhere
  always_comb begin
    state_nxt = state;
    if (!bus.cfg_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:       if (bus.start) state_nxt = WAIT_HIGH;
        WAIT_HIGH:  if (rx_sync)   state_nxt = WAIT_EDGE1;
        WAIT_EDGE1: if (fall)      state_nxt = MEASURE;
        MEASURE: begin
          if (at_max)                                        state_nxt = ERROR;
          else if (fall && (edge_idx != IDX_W'(1)) && mismatch) state_nxt = ERROR;
          else if (fall && (edge_idx == IDX_W'(4)))           state_nxt = CALC;
        end
        CALC:       state_nxt = range_bad ? ERROR : IDLE;
        ERROR:      state_nxt = IDLE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  // Register next values for datapath and outputs
  always_comb begin
    cnt_nxt       = cnt;
    prev_snap_nxt = prev_snap;
    t1_nxt        = t1;
    c_total_nxt   = c_total;
    edge_idx_nxt  = edge_idx;
    err_pend_nxt  = err_pend;
    err_code_nxt  = err_code_q;
    busy_nxt      = busy_q;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    valid_nxt     = valid_q;
    baud_nxt      = baud_q;
    if (!bus.cfg_en) begin
      busy_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_nxt     = 1'b1;
            valid_nxt    = 1'b0;
            err_code_nxt = 2'b00;
          end
        end
        WAIT_EDGE1: begin
          if (fall) begin
            cnt_nxt       = '0;
            prev_snap_nxt = '0;
            edge_idx_nxt  = IDX_W'(1);
          end
        end
        MEASURE: begin
          cnt_nxt = snap;
          if (at_max) begin
            err_pend_nxt = 2'b01;
          end else if (fall) begin
            prev_snap_nxt = snap;
            edge_idx_nxt  = edge_idx + IDX_W'(1);
            if (edge_idx == IDX_W'(1)) t1_nxt = ti;
            else if (mismatch)         err_pend_nxt = 2'b10;
            else if (edge_idx == IDX_W'(4)) c_total_nxt = snap;
          end
        end
        CALC: begin
          if (range_bad) begin
            err_pend_nxt = 2'b11;
          end else begin
            baud_nxt  = 12'(div - EXT_W'(2));
            done_nxt  = 1'b1;
            valid_nxt = 1'b1;
            busy_nxt  = 1'b0;
          end
        end
        ERROR: begin
          err_nxt      = 1'b1;
          err_code_nxt = err_pend;
          valid_nxt    = 1'b0;
          busy_nxt     = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;
  assign bus.baud_valid = valid_q;
  assign bus.baud_16x   = baud_q;

endmodule
